// File: rtl/spi_slave_core.sv
// SPI slave with TX/RX FIFOs behind a Wishbone register interface.
// SPI inputs are synchronised into wb_clk_i and edge-detected.
`timescale 1ns/1ps
module spi_slave_core #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int LSB_FIRST  = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [1:0]        wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  input  logic              spi_scsn_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe,
  output logic              irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic IDLE_LVL = (CPOL != 0);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t            state_q;
  logic [2:0]        sclk_q, csn_q;
  logic [1:0]        mosi_q;
  logic              ack_q, en_q, flush_q, rxie_q, errie_q;
  logic              rxovr_q, txur_q, abort_q, txovr_q;
  logic              irq_q, miso_q, oe_q;
  logic [DATA_W-1:0] dat_q, rx_q, tx_shift_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CW-1:0]     tx_cnt_q, rx_cnt_q;

  logic sclk_lead, sclk_trail, csn_fall, csn_rise, sample_edge, shift_edge;
  logic active, start, leave, sample, word_done, load;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic wb_req, wr, rd, tx_push, tx_pop, rx_push, rx_pop, sr_wr, cr_wr;
  logic txovr_set, txur_set, rxovr_set, abort_set;
  logic [3:0]        sticky_clr;
  logic [BW-1:0]     rx_idx;
  logic [DATA_W-1:0] rx_d, tx_word, tx_word_sh, tx_shift_sh, sr_val, cr_val, rd_data;
  logic              tx_first, tx_out;

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign sclk_lead   = (sclk_q[2] == IDLE_LVL) && (sclk_q[1] != IDLE_LVL);
  assign sclk_trail  = (sclk_q[2] != IDLE_LVL) && (sclk_q[1] == IDLE_LVL);
  assign csn_fall    = csn_q[2] & ~csn_q[1];
  assign csn_rise    = ~csn_q[2] & csn_q[1];
  assign sample_edge = (CPHA != 0) ? sclk_trail : sclk_lead;
  // In mode CPHA=0 the first bit of each word is driven at load, so the
  // trailing edge right after a word boundary must not shift again.
  assign shift_edge  = (CPHA != 0) ? sclk_lead : (sclk_trail & (bit_cnt_q != '0));

  assign active    = (state_q == ST_ACTIVE);
  assign start     = ~active & csn_fall & en_q;
  assign leave     = active & (csn_rise | ~en_q);
  assign sample    = active & ~leave & sample_edge;
  assign word_done = sample & (bit_cnt_q == LAST_BIT);
  assign load      = start | word_done;

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  assign wb_req    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr        = wb_req & wb_we_i;
  assign rd        = wb_req & ~wb_we_i;
  assign tx_push   = wr & (wb_adr_i == 2'd0) & ~tx_full;
  assign txovr_set = wr & (wb_adr_i == 2'd0) & tx_full;
  assign rx_pop    = rd & (wb_adr_i == 2'd1) & ~rx_empty;
  assign sr_wr     = wr & (wb_adr_i == 2'd2);
  assign cr_wr     = wr & (wb_adr_i == 2'd3);
  assign sticky_clr = sr_wr ? wb_dat_i[7:4] : 4'b0000;

  assign tx_pop    = load & ~tx_empty;
  assign txur_set  = load & tx_empty;
  assign rx_push   = word_done & ~rx_full;
  assign rxovr_set = word_done & rx_full;
  assign abort_set = active & csn_rise & (bit_cnt_q != '0);

  assign tx_word     = tx_empty ? '0 : tx_mem[tx_rp_q];
  assign tx_first    = (LSB_FIRST != 0) ? tx_word[0] : tx_word[DATA_W-1];
  assign tx_word_sh  = (LSB_FIRST != 0) ? (tx_word >> 1) : (tx_word << 1);
  assign tx_out      = (LSB_FIRST != 0) ? tx_shift_q[0] : tx_shift_q[DATA_W-1];
  assign tx_shift_sh = (LSB_FIRST != 0) ? (tx_shift_q >> 1) : (tx_shift_q << 1);
  assign rx_idx      = (LSB_FIRST != 0) ? bit_cnt_q : (LAST_BIT - bit_cnt_q);

  always_comb begin
    rx_d = rx_q;
    rx_d[rx_idx] = mosi_q[1];
    sr_val = '0;
    sr_val[7:0] = {txovr_q, abort_q, txur_q, rxovr_q, rx_empty, rx_full, tx_empty, tx_full};
    cr_val = '0;
    cr_val[3:0] = {errie_q, rxie_q, flush_q, en_q};
    case (wb_adr_i)
      2'd1:    rd_data = rx_empty ? '0 : rx_mem[rx_rp_q];
      2'd2:    rd_data = sr_val;
      2'd3:    rd_data = cr_val;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (tx_push) tx_mem[tx_wp_q] <= wb_dat_i;
    if (rx_push) rx_mem[rx_wp_q] <= rx_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      sclk_q     <= {3{IDLE_LVL}};
      csn_q      <= '1;
      mosi_q     <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      en_q       <= 1'b0;
      flush_q    <= 1'b0;
      rxie_q     <= 1'b0;
      errie_q    <= 1'b0;
      rxovr_q    <= 1'b0;
      txur_q     <= 1'b0;
      abort_q    <= 1'b0;
      txovr_q    <= 1'b0;
      irq_q      <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_shift_q <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_clk_i};
      csn_q  <= {csn_q[1:0], spi_scsn_i};
      mosi_q <= {mosi_q[0], spi_mosi_i};

      ack_q <= wb_req;
      dat_q <= rd ? rd_data : '0;

      flush_q <= cr_wr & wb_dat_i[1];
      if (cr_wr) begin
        en_q    <= wb_dat_i[0];
        rxie_q  <= wb_dat_i[2];
        errie_q <= wb_dat_i[3];
      end

      rxovr_q <= rxovr_set | (rxovr_q & ~sticky_clr[0]);
      txur_q  <= txur_set  | (txur_q  & ~sticky_clr[1]);
      abort_q <= abort_set | (abort_q & ~sticky_clr[2]);
      txovr_q <= txovr_set | (txovr_q & ~sticky_clr[3]);

      irq_q <= (rxie_q & ~rx_empty) | (errie_q & (rxovr_q | txur_q | abort_q | txovr_q));

      if (flush_q) begin
        tx_wp_q  <= '0;
        tx_rp_q  <= '0;
        rx_wp_q  <= '0;
        rx_rp_q  <= '0;
        tx_cnt_q <= '0;
        rx_cnt_q <= '0;
      end else begin
        if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
        if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
        if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
        if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
        tx_cnt_q <= tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_q <= rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      end

      unique case (state_q)
        ST_IDLE: begin
          miso_q    <= 1'b0;
          oe_q      <= 1'b0;
          bit_cnt_q <= '0;
          if (start) begin
            state_q <= ST_ACTIVE;
            oe_q    <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (leave) begin
            state_q   <= ST_IDLE;
            oe_q      <= 1'b0;
            miso_q    <= 1'b0;
            bit_cnt_q <= '0;
          end else if (sample) begin
            rx_q      <= rx_d;
            bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
          end else if (shift_edge) begin
            miso_q     <= tx_out;
            tx_shift_q <= tx_shift_sh;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (load) begin
        if (CPHA == 0) begin
          miso_q     <= tx_first;
          tx_shift_q <= tx_word_sh;
        end else begin
          tx_shift_q <= tx_word;
        end
      end
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign spi_miso_o  = miso_q;
  assign spi_miso_oe = oe_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: instance A is mode 0 / LSB first, instance B is CPOL=1,
// CPHA=1, MSB first; the bench plays SPI master and Wishbone master.
`timescale 1ns/1ps
module tb_spi_slave_core;

  localparam int H = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cyc_a = 1'b0, cyc_b = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0] adr = 2'd0;
  logic [7:0] wdat = 8'h00;
  logic [7:0] dat_a, dat_b;
  logic       ack_a, ack_b;
  logic       sclk_a = 1'b0, sclk_b = 1'b1, mosi = 1'b0, csn_a = 1'b1, csn_b = 1'b1;
  logic       miso_a, oe_a, irq_a, miso_b, oe_b, irq_b;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  spi_slave_core #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0), .LSB_FIRST(1)) u_a (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_a), .wb_ack_o(ack_a),
    .spi_clk_i(sclk_a), .spi_mosi_i(mosi), .spi_scsn_i(csn_a),
    .spi_miso_o(miso_a), .spi_miso_oe(oe_a), .irq_o(irq_a));

  spi_slave_core #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(1), .CPHA(1), .LSB_FIRST(0)) u_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_b), .wb_ack_o(ack_b),
    .spi_clk_i(sclk_b), .spi_mosi_i(mosi), .spi_scsn_i(csn_b),
    .spi_miso_o(miso_b), .spi_miso_oe(oe_b), .irq_o(irq_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input int sel, input logic w, input logic [1:0] a,
                         input logic [7:0] d, output logic [7:0] r);
    logic got;
    got = 1'b0;
    r = 8'h00;
    @(posedge clk); #1;
    stb = 1'b1; we = w; adr = a; wdat = d;
    if (sel == 0) cyc_a = 1'b1; else cyc_b = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if ((sel == 0) ? ack_a : ack_b) begin
        got = 1'b1;
        r = (sel == 0) ? dat_a : dat_b;
      end
    end
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
    check("wb_ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wb_wr(input int sel, input logic [1:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    wb_xfer(sel, 1'b1, a, d, dummy);
  endtask

  task automatic wb_rd(input int sel, input logic [1:0] a, output logic [7:0] r);
    wb_xfer(sel, 1'b0, a, 8'h00, r);
  endtask

  task automatic set_sclk(input int sel, input logic v);
    if (sel == 0) sclk_a = v; else sclk_b = v;
  endtask

  task automatic set_csn(input int sel, input logic v);
    if (sel == 0) csn_a = v; else csn_b = v;
  endtask

  task automatic frame_begin(input int sel);
    set_csn(sel, 1'b0);
    #H;
  endtask

  task automatic frame_end(input int sel);
    #H;
    set_csn(sel, 1'b1);
    #(2*H);
  endtask

  // Master side of nbits bit-times; returns the MISO bits it sampled.
  task automatic spi_word(input int sel, input logic [7:0] m, input int nbits,
                          output logic [7:0] s);
    logic cpol, cpha, lsb;
    int b;
    cpol = (sel != 0); cpha = (sel != 0); lsb = (sel == 0);
    s = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = lsb ? i : 7 - i;
      if (!cpha) begin
        mosi = m[b];
        #H;
        set_sclk(sel, ~cpol);
        s[b] = (sel == 0) ? miso_a : miso_b;
        #H;
        set_sclk(sel, cpol);
      end else begin
        set_sclk(sel, ~cpol);
        mosi = m[b];
        #H;
        set_sclk(sel, cpol);
        s[b] = (sel == 0) ? miso_a : miso_b;
        #H;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d, s;
    logic [7:0] mw [5];
    logic [7:0] tw [5];
    mw = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    tw = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("reset_outs_a", {19'd0, ack_a, dat_a, miso_a, oe_a, irq_a}, 32'd0);
    check("reset_outs_b", {19'd0, ack_b, dat_b, miso_b, oe_b, irq_b}, 32'd0);
    rst_n = 1'b1;
    wb_rd(0, 2'd2, d); check("reset_sr", d, 8'h0A);
    wb_rd(0, 2'd3, d); check("reset_cr", d, 8'h00);

    // Mode 0 LSB-first single word
    wb_wr(0, 2'd0, 8'hA5);
    wb_wr(0, 2'd3, 8'h01);
    frame_begin(0);
    check("oe_active", oe_a, 1);
    spi_word(0, 8'h3C, 8, s);
    frame_end(0);
    check("miso_word_a5", s, 8'hA5);
    check("oe_idle", oe_a, 0);
    check("miso_idle", miso_a, 0);
    wb_rd(0, 2'd1, d); check("rxdr_3c", d, 8'h3C);
    wb_rd(0, 2'd2, d); check("sr_after_read", d & 8'h0F, 8'h0A);
    wb_rd(0, 2'd1, d); check("rxdr_empty_zero", d, 8'h00);

    // TX underrun
    wb_wr(0, 2'd2, 8'hF0);
    wb_rd(0, 2'd2, d); check("sr_cleared", d, 8'h0A);
    frame_begin(0);
    spi_word(0, 8'h55, 8, s);
    frame_end(0);
    check("miso_underrun_zero", s, 8'h00);
    wb_rd(0, 2'd2, d); check("sr_txur", d, 8'h22);
    wb_wr(0, 2'd2, 8'h20);
    wb_rd(0, 2'd2, d); check("sr_txur_w1c", d, 8'h02);
    wb_rd(0, 2'd1, d); check("rxdr_55", d, 8'h55);

    // Abort after 3 bits, then a clean frame
    wb_wr(0, 2'd0, 8'h11);
    frame_begin(0);
    spi_word(0, 8'hFF, 3, s);
    frame_end(0);
    wb_rd(0, 2'd2, d); check("sr_abort", d, 8'h4A);
    wb_wr(0, 2'd2, 8'h40);
    wb_rd(0, 2'd2, d); check("sr_abort_w1c", d, 8'h0A);
    wb_wr(0, 2'd0, 8'h96);
    frame_begin(0);
    spi_word(0, 8'hC3, 8, s);
    frame_end(0);
    check("miso_after_abort", s, 8'h96);
    wb_rd(0, 2'd1, d); check("rxdr_after_abort", d, 8'hC3);

    // FIFO full / overrun / interrupt
    wb_wr(0, 2'd2, 8'hF0);
    wb_wr(0, 2'd3, 8'h09);
    for (int i = 0; i < 4; i++) wb_wr(0, 2'd0, tw[i]);
    wb_rd(0, 2'd2, d); check("sr_txfull", d, 8'h09);
    check("irq_quiet", irq_a, 0);
    wb_wr(0, 2'd0, 8'hEE);
    wb_rd(0, 2'd2, d); check("sr_txovr", d, 8'h89);
    check("irq_txovr", irq_a, 1);
    wb_wr(0, 2'd2, 8'h80);
    frame_begin(0);
    for (int i = 0; i < 5; i++) begin
      spi_word(0, mw[i], 8, s);
      check("miso_burst", s, tw[i]);
    end
    frame_end(0);
    wb_rd(0, 2'd2, d); check("sr_rxfull_ovr", d, 8'h36);
    check("irq_rxovr", irq_a, 1);
    for (int i = 0; i < 4; i++) begin
      wb_rd(0, 2'd1, d); check("rxdr_burst", d, mw[i]);
    end
    wb_rd(0, 2'd2, d); check("sr_after_drain", d, 8'h3A);

    // Single-cycle ack with strobe held through the ack cycle
    wb_wr(0, 2'd2, 8'hF0);
    @(posedge clk); #1;
    cyc_a = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd3;
    @(posedge clk); #1;
    check("ack_pulse", {ack_a, dat_a}, {1'b1, 8'h09});
    @(posedge clk); #1;
    check("ack_no_reack", ack_a, 0);
    cyc_a = 1'b0; stb = 1'b0;

    // Flush
    wb_wr(0, 2'd0, 8'hAA);
    wb_wr(0, 2'd0, 8'hBB);
    wb_rd(0, 2'd2, d); check("sr_before_flush", d, 8'h08);
    wb_wr(0, 2'd3, 8'h0B);
    wb_rd(0, 2'd2, d); check("sr_after_flush", d, 8'h0A);
    wb_rd(0, 2'd3, d); check("cr_flush_selfclear", d, 8'h09);

    // Reset mid-frame and during a Wishbone ack
    wb_wr(0, 2'd3, 8'h05);
    wb_wr(0, 2'd0, 8'h0F);
    wb_wr(0, 2'd0, 8'h0F);
    frame_begin(0);
    spi_word(0, 8'h77, 8, s);
    check("miso_pre_reset", s, 8'h0F);
    spi_word(0, 8'h00, 3, s);
    check("live_oe_irq_miso", {oe_a, irq_a, miso_a}, 3'b111);
    @(posedge clk); #1;
    cyc_a = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd2;
    @(posedge clk); #1;
    check("ack_before_reset", ack_a, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("outs_after_reset", {19'd0, ack_a, dat_a, miso_a, oe_a, irq_a}, 32'd0);
    cyc_a = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    csn_a = 1'b1;
    #(2*H);
    wb_rd(0, 2'd2, d); check("sr_after_reset", d, 8'h0A);
    wb_rd(0, 2'd3, d); check("cr_after_reset", d, 8'h00);

    // CPOL=1 CPHA=1 MSB first, two words in one frame
    wb_wr(1, 2'd0, 8'h81);
    wb_wr(1, 2'd0, 8'h7E);
    wb_wr(1, 2'd3, 8'h01);
    frame_begin(1);
    check("oe_b_active", oe_b, 1);
    spi_word(1, 8'hC5, 8, s);
    check("miso_b_w0", s, 8'h81);
    spi_word(1, 8'h3A, 8, s);
    check("miso_b_w1", s, 8'h7E);
    frame_end(1);
    wb_rd(1, 2'd1, d); check("rxdr_b_w0", d, 8'hC5);
    wb_rd(1, 2'd1, d); check("rxdr_b_w1", d, 8'h3A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8; SPI word and Wishbone data width, legal 8..32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; TX and RX FIFO depth in words, power of two, 2..64.
REQ-003 SHALL have parameter CPOL, default 0; SPI clock idle level.
REQ-004 SHALL have parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 SHALL have parameter LSB_FIRST, default 1; 1 = bit 0 shifted first, 0 = MSB first.
REQ-006 SHALL use one clock and a synchronous, active-low reset: wb_clk_i (clock) and wb_rst_n_i (reset).
REQ-007 Ports, in order:
- wb_clk_i  in  1  system clock
- wb_rst_n_i  in  1  synchronous reset, active low
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  Wishbone write enable
- wb_adr_i  in  2  register address
- wb_dat_i  in  DATA_W  write data
- wb_dat_o  out  DATA_W  read data
- wb_ack_o  out  1  Wishbone acknowledge
- spi_clk_i  in  1  SPI clock, asynchronous
- spi_mosi_i  in  1  master-out data, asynchronous
- spi_scsn_i  in  1  chip select, active low, asynchronous
- spi_miso_o  out  1  slave-out data
- spi_miso_oe  out  1  MISO output enable
- irq_o  out  1  level interrupt

Function
REQ-008 SHALL pass spi_clk_i, spi_mosi_i and spi_scsn_i through a 2-flop synchroniser before use, and detect edges on the synchronised signals; correct operation requires wb_clk_i >= 4x SPI clock.
REQ-009 Wishbone: wb_ack_o SHALL pulse high for exactly 1 cycle, 1 cycle after the first cycle with wb_cyc_i & wb_stb_i; it SHALL NOT re-ack while stb is held during the ack cycle.
REQ-010 Register map:
- 0 TXDR: write only; push to TX FIFO.
- 1 RXDR: read only; pop from RX FIFO.
- 2 SR: read; write 1 clears sticky bits.
- 3 CR: read/write.
REQ-011 SR bits: 0 TXFULL, 1 TXEMPTY, 2 RXFULL, 3 RXEMPTY, 4 RXOVR, 5 TXUR, 6 ABORT, 7 TXOVR, 8.. zero. Bits 4-7 are sticky.
REQ-012 CR bits: 0 EN, 1 FLUSH (self-clearing, empties both FIFOs next cycle), 2 RXIE, 3 ERRIE.
REQ-013 A TXDR write when TX FIFO is full SHALL be dropped and set TXOVR.
REQ-014 An RXDR read when RX FIFO is empty SHALL return 0 with no pop.
REQ-015 A simultaneous push and pop on the same FIFO SHALL both take effect; the count is unchanged.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 FSM states and transitions:
- IDLE -> ACTIVE on synced scsn falling edge while EN=1.
- ACTIVE -> IDLE on synced scsn rising edge or when EN is cleared.
REQ-018 On entering ACTIVE, and after each completed word while scsn stays low, the TX shift register SHALL load the TX FIFO head (pop). If the TX FIFO is empty it SHALL load all zeros and set TXUR.
REQ-019 MISO driving:
- CPHA=0: first bit driven on spi_miso_o at load; subsequent bits updated on trailing edges.
- CPHA=1: bits updated on leading edges.
REQ-020 MOSI SHALL be sampled on the sample edge per CPHA; the bit counter counts 0..DATA_W-1.
REQ-021 After DATA_W samples the assembled word SHALL be pushed to the RX FIFO within 1 cycle. If the RX FIFO is full the word is dropped and RXOVR is set.
REQ-022 Deassertion of scsn mid-word SHALL discard the partial word, set ABORT and reset the bit counter; a word already popped from TX is not restored.
REQ-023 spi_miso_oe SHALL be 1 only in ACTIVE; spi_miso_o SHALL be 0 in IDLE.
REQ-024 irq_o = (RXIE & ~RXEMPTY) | (ERRIE & (RXOVR | TXUR | ABORT | TXOVR)), registered.
REQ-025 When a sticky set and a W1C clear occur in the same cycle, set SHALL win.

Reset
REQ-026 With wb_rst_n_i low at a clock edge, the block SHALL set:
- FSM to IDLE, FIFOs empty, all SR sticky bits 0, CR = 0;
- wb_ack_o, wb_dat_o, spi_miso_o, spi_miso_oe, irq_o = 0;
- synchronisers to the idle levels (scsn=1, clk=CPOL).
REQ-027 Reset asserted mid-frame SHALL abort the frame without setting ABORT.

Verification
REQ-028 DATA_W=8, mode 0, LSB first: write TXDR=0xA5, CR=0x01; master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RXDR reads 0x3C; SR RXEMPTY=1 afterwards.
REQ-029 CPOL=1, CPHA=1, MSB first: 2 back-to-back words in one frame with TX 0x81, 0x7E -> master receives 0x81, 0x7E; RX FIFO holds both master words in order.
REQ-030 FIFO_DEPTH=4: master sends 5 words with no reads -> RXFULL=1, RXOVR=1, first 4 words read back intact; irq_o=1 with ERRIE=1.
REQ-031 TX FIFO empty at frame start -> MISO all zeros and TXUR=1; writing SR=0x20 clears TXUR.
REQ-032 scsn raised after 3 bits -> no RX push, ABORT=1; the next full frame is received correctly.
REQ-033 Reset asserted mid-frame and during a Wishbone ack -> all outputs 0 on the next cycle; SR reads 0x0A (TXEMPTY, RXEMPTY).
